// File: rtl/vga_pkg.sv
// Shared VGA timing description: mode record, standard presets and the
// derived line/frame totals used by the timing pipeline.
package vga_pkg;

   // One display mode. Units are pixel ticks horizontally and lines vertically.
   typedef struct packed {
      int unsigned h_active;
      int unsigned h_pulse;
      int unsigned h_back;
      int unsigned h_front;
      int unsigned v_active;
      int unsigned v_pulse;
      int unsigned v_back;
      int unsigned v_front;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480_60 = '{
      h_active: 640, h_pulse: 96,  h_back: 48, h_front: 16,
      v_active: 480, v_pulse: 2,   v_back: 33, v_front: 10
   };

   localparam vga_timing_t VGA_800X600_60 = '{
      h_active: 800, h_pulse: 128, h_back: 88, h_front: 40,
      v_active: 600, v_pulse: 4,   v_back: 23, v_front: 1
   };

   // Line order is sync, back porch, active, front porch.
   function automatic int unsigned h_total(input vga_timing_t t);
      return t.h_pulse + t.h_back + t.h_active + t.h_front;
   endfunction

   function automatic int unsigned v_total(input vga_timing_t t);
      return t.v_pulse + t.v_back + t.v_active + t.v_front;
   endfunction

   // First active column / row counted from the start of the sync pulse.
   function automatic int unsigned h_active_start(input vga_timing_t t);
      return t.h_pulse + t.h_back;
   endfunction

   function automatic int unsigned v_active_start(input vga_timing_t t);
      return t.v_pulse + t.v_back;
   endfunction

endpackage

// File: rtl/vga_ce_delay.sv
// Clock-enable gated shift register with synchronous reset to zero.
// A depth of zero degenerates to a plain wire.
module vga_ce_delay
   import vga_pkg::*;
#(
   parameter int width = 1,
   parameter int depth = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             ce_i,
   input  logic [width-1:0] d_i,
   output logic [width-1:0] q_o
);

   if (depth == 0) begin : g_wire
      assign q_o = d_i;
   end else begin : g_shift
      logic [width-1:0] stage_q [depth];

      // Shift one stage per enabled tick; reset clears every stage.
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int i = 0; i < depth; i++) stage_q[i] <= '0;
         end else if (ce_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < depth; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[depth-1];
   end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with ahead-of-display pixel requests. Syncs and
// display enable are delayed to match a fixed-latency pixel fetch so that
// colour, syncs and enable leave on the same registered edge.
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter int unsigned width_p          = 640,
   parameter int unsigned height_p         = 480,
   parameter int unsigned h_sync_pulse_p   = 96,
   parameter int unsigned h_back_porch_p   = 48,
   parameter int unsigned h_front_porch_p  = 16,
   parameter int unsigned v_sync_pulse_p   = 2,
   parameter int unsigned v_back_porch_p   = 33,
   parameter int unsigned v_front_porch_p  = 10,
   parameter bit          hs_active_high_p = 1'b0,
   parameter bit          vs_active_high_p = 1'b0,
   parameter int unsigned latency_p        = 2,
   parameter int unsigned bit_depth_p      = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          pix_ce_i,
   output logic [$clog2(width_p)-1:0]    req_x_o,
   output logic [$clog2(height_p)-1:0]   req_y_o,
   output logic                          req_v_o,
   input  logic [bit_depth_p-1:0]        r_i,
   input  logic [bit_depth_p-1:0]        g_i,
   input  logic [bit_depth_p-1:0]        b_i,
   output logic [bit_depth_p-1:0]        r_o,
   output logic [bit_depth_p-1:0]        g_o,
   output logic [bit_depth_p-1:0]        b_o,
   output logic                          hs_o,
   output logic                          vs_o,
   output logic                          de_o,
   output logic                          sof_o,
   output logic                          vblank_o
);

   if (latency_p > 7 || width_p == 0 || height_p == 0 ||
       h_sync_pulse_p == 0 || h_back_porch_p == 0 || h_front_porch_p == 0 ||
       v_sync_pulse_p == 0 || v_back_porch_p == 0 || v_front_porch_p == 0) begin : g_bad_params
      $fatal(1, "vga_timing_pipe: latency_p above 7 or zero-length timing parameter");
   end

   localparam vga_timing_t TIM = '{
      h_active: width_p,  h_pulse: h_sync_pulse_p, h_back: h_back_porch_p, h_front: h_front_porch_p,
      v_active: height_p, v_pulse: v_sync_pulse_p, v_back: v_back_porch_p, v_front: v_front_porch_p
   };

   localparam int unsigned H_TOT = h_total(TIM);
   localparam int unsigned V_TOT = v_total(TIM);
   localparam int HW = $clog2(H_TOT);
   localparam int VW = $clog2(V_TOT);
   localparam int XW = $clog2(width_p);
   localparam int YW = $clog2(height_p);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOT - 1);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(h_sync_pulse_p);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(v_sync_pulse_p);
   localparam logic [HW-1:0] H_ACT_FIRST = HW'(h_active_start(TIM));
   localparam logic [HW-1:0] H_ACT_LAST  = HW'(h_active_start(TIM) + width_p - 1);
   localparam logic [VW-1:0] V_ACT_FIRST = VW'(v_active_start(TIM));
   localparam logic [VW-1:0] V_ACT_LAST  = VW'(v_active_start(TIM) + height_p - 1);

   // Output level while the sync pulse is not active.
   localparam logic HS_IDLE = ~hs_active_high_p;
   localparam logic VS_IDLE = ~vs_active_high_p;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [HW-1:0] h_eff;
   logic [VW-1:0] v_eff;
   logic          h_act;
   logic          v_act;
   logic          hs_raw;
   logic          vs_raw;
   logic [2:0]    dly_in;
   logic [2:0]    dly_out;

   // Raster counters: h wraps each line, v steps on every h wrap.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce_i) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   // While reset is held the request side already shows position 0,0.
   assign h_eff = reset_i ? '0 : h_cnt;
   assign v_eff = reset_i ? '0 : v_cnt;

   assign h_act  = (h_eff >= H_ACT_FIRST) && (h_eff <= H_ACT_LAST);
   assign v_act  = (v_eff >= V_ACT_FIRST) && (v_eff <= V_ACT_LAST);
   assign hs_raw = h_eff < H_SYNC_END;
   assign vs_raw = v_eff < V_SYNC_END;

   assign req_v_o  = h_act & v_act;
   assign req_x_o  = XW'(h_eff - H_ACT_FIRST);
   assign req_y_o  = YW'(v_eff - V_ACT_FIRST);
   assign sof_o    = pix_ce_i & (h_eff == '0) & (v_eff == '0);
   assign vblank_o = pix_ce_i & ~v_act;

   assign dly_in = {hs_raw, vs_raw, req_v_o};

   vga_ce_delay #(
      .width (3),
      .depth (int'(latency_p))
   ) u_align (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .ce_i    (pix_ce_i),
      .d_i     (dly_in),
      .q_o     (dly_out)
   );

   // Output stage: polarity applied to syncs, colour blanked outside the active area.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hs_o <= HS_IDLE;
         vs_o <= VS_IDLE;
         de_o <= 1'b0;
         r_o  <= '0;
         g_o  <= '0;
         b_o  <= '0;
      end else if (pix_ce_i) begin
         hs_o <= dly_out[2] ^ HS_IDLE;
         vs_o <= dly_out[1] ^ VS_IDLE;
         de_o <= dly_out[0];
         r_o  <= dly_out[0] ? r_i : '0;
         g_o  <= dly_out[0] ? g_i : '0;
         b_o  <= dly_out[0] ? b_i : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe on a small custom mode (23 x 11 ticks/lines).
// The reference model tracks only the number of enabled ticks since reset
// and derives raster position, syncs, enable and colour arithmetically.
module tb_vga_timing_pipe;

   localparam int W   = 16;
   localparam int HGT = 6;
   localparam int HSP = 3;
   localparam int HBP = 2;
   localparam int HFP = 2;
   localparam int VSP = 2;
   localparam int VBP = 2;
   localparam int VFP = 1;
   localparam int LAT = 3;
   localparam int HT  = HSP + HBP + W + HFP;    // 23
   localparam int VT  = VSP + VBP + HGT + VFP;  // 11
   localparam bit HS_AH = 1'b1;
   localparam bit VS_AH = 1'b0;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       pix_ce_i = 1'b0;
   logic [3:0] req_x_o;
   logic [2:0] req_y_o;
   logic       req_v_o;
   logic [7:0] r_i = '0, g_i = '0, b_i = '0;
   logic [7:0] r_o, g_o, b_o;
   logic       hs_o, vs_o, de_o, sof_o, vblank_o;

   vga_timing_pipe #(
      .width_p(W), .height_p(HGT),
      .h_sync_pulse_p(HSP), .h_back_porch_p(HBP), .h_front_porch_p(HFP),
      .v_sync_pulse_p(VSP), .v_back_porch_p(VBP), .v_front_porch_p(VFP),
      .hs_active_high_p(HS_AH), .vs_active_high_p(VS_AH),
      .latency_p(LAT), .bit_depth_p(8)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .pix_ce_i(pix_ce_i),
      .req_x_o(req_x_o), .req_y_o(req_y_o), .req_v_o(req_v_o),
      .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .r_o(r_o), .g_o(g_o), .b_o(b_o),
      .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
      .sof_o(sof_o), .vblank_o(vblank_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;      // enabled ticks since the last reset
   bit started  = 1'b0;
   int salt     = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d tick %0d)", name, act, exp, cyc, k);
      end
   endtask

   function automatic bit is_active(input int h, input int v);
      return (h >= HSP + HBP) && (h < HSP + HBP + W) && (v >= VSP + VBP) && (v < VSP + VBP + HGT);
   endfunction

   function automatic logic [7:0] col(input int ch, input int x, input int y);
      return 8'((x * (ch + 3) + y * (2 * ch + 5) + salt + ch * 40) & 255);
   endfunction

   function automatic logic [7:0] junk();
      return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
   endfunction

   // Drive this tick's inputs and compare every output with the model.
   task automatic drive_and_check(input bit ce, input bit rst);
      int h, v, t, th, tv;
      logic ehs, evs, ede;
      logic [7:0] er, eg, eb;
      @(negedge clk_i);
      pix_ce_i = ce;
      reset_i  = rst;
      t = k - LAT;
      if (started && !rst && t >= 0 && is_active(t % HT, (t / HT) % VT)) begin
         r_i = col(0, t % HT - HSP - HBP, (t / HT) % VT - VSP - VBP);
         g_i = col(1, t % HT - HSP - HBP, (t / HT) % VT - VSP - VBP);
         b_i = col(2, t % HT - HSP - HBP, (t / HT) % VT - VSP - VBP);
      end else begin
         r_i = junk();
         g_i = junk();
         b_i = junk();
      end
      #1;
      h = rst ? 0 : k % HT;
      v = rst ? 0 : (k / HT) % VT;
      chk("req_v", req_v_o, is_active(h, v));
      if (is_active(h, v)) begin
         chk("req_x", req_x_o, h - HSP - HBP);
         chk("req_y", req_y_o, v - VSP - VBP);
      end
      chk("sof", sof_o, ce && h == 0 && v == 0);
      chk("vblank", vblank_o, ce && (v < VSP + VBP || v >= VSP + VBP + HGT));
      if (started) begin
         if (k < LAT + 1) begin
            ehs = !HS_AH; evs = !VS_AH; ede = 1'b0;
            er = '0; eg = '0; eb = '0;
         end else begin
            t  = k - LAT - 1;
            th = t % HT;
            tv = (t / HT) % VT;
            ehs = ((th < HSP) == HS_AH);
            evs = ((tv < VSP) == VS_AH);
            ede = is_active(th, tv);
            er = ede ? col(0, th - HSP - HBP, tv - VSP - VBP) : 8'h00;
            eg = ede ? col(1, th - HSP - HBP, tv - VSP - VBP) : 8'h00;
            eb = ede ? col(2, th - HSP - HBP, tv - VSP - VBP) : 8'h00;
         end
         chk("hs_o", hs_o, ehs);
         chk("vs_o", vs_o, evs);
         chk("de_o", de_o, ede);
         chk("r_o", r_o, er);
         chk("g_o", g_o, eg);
         chk("b_o", b_o, eb);
      end
   endtask

   task automatic advance(input bit ce, input bit rst);
      @(posedge clk_i);
      if (rst) begin
         k = 0;
         started = 1'b1;
      end else if (ce) begin
         k++;
      end
      cyc++;
   endtask

   task automatic step(input bit ce, input bit rst);
      drive_and_check(ce, rst);
      advance(ce, rst);
   endtask

   typedef struct {
      int k;
      bit rv; int x; int y;
      bit sof; bit vb;
      bit hs; bit vs; bit de;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int cnt_de, cnt_sof, cnt_hs, cnt_vs, last_rise;
      bit prev_hs, ce, rst;

      // Checkpoints after reset with ce held high (hs active high, vs active low).
      //           k    rv x   y  sof vb hs vs de
      vecs[0]  = '{0,   0, 0,  0, 1,  1, 0, 1, 0};
      vecs[1]  = '{3,   0, 0,  0, 0,  1, 0, 1, 0};
      vecs[2]  = '{4,   0, 0,  0, 0,  1, 1, 0, 0};
      vecs[3]  = '{7,   0, 0,  0, 0,  1, 0, 0, 0};
      vecs[4]  = '{97,  1, 0,  0, 0,  0, 1, 1, 0};
      vecs[5]  = '{101, 1, 4,  0, 0,  0, 0, 1, 1};
      vecs[6]  = '{135, 1, 15, 1, 0,  0, 0, 1, 1};
      vecs[7]  = '{136, 0, 0,  0, 0,  0, 0, 1, 1};
      vecs[8]  = '{140, 0, 0,  0, 0,  0, 0, 1, 0};
      vecs[9]  = '{227, 1, 15, 5, 0,  0, 0, 1, 1};
      vecs[10] = '{230, 0, 0,  0, 0,  1, 0, 1, 1};
      vecs[11] = '{253, 0, 0,  0, 1,  1, 0, 1, 0};
      vecs[12] = '{257, 0, 0,  0, 0,  1, 1, 0, 0};

      salt = int'($urandom_range(0, 255));

      step(1'b1, 1'b1);
      step(1'b1, 1'b1);

      foreach (vecs[i]) begin
         while (k < vecs[i].k) step(1'b1, 1'b0);
         drive_and_check(1'b1, 1'b0);
         chk("tbl_req_v", req_v_o, vecs[i].rv);
         if (vecs[i].rv) begin
            chk("tbl_req_x", req_x_o, vecs[i].x);
            chk("tbl_req_y", req_y_o, vecs[i].y);
         end
         chk("tbl_sof", sof_o, vecs[i].sof);
         chk("tbl_vblank", vblank_o, vecs[i].vb);
         chk("tbl_hs", hs_o, vecs[i].hs);
         chk("tbl_vs", vs_o, vecs[i].vs);
         chk("tbl_de", de_o, vecs[i].de);
         if (!vecs[i].de) chk("tbl_r_blank", r_o, 0);
         advance(1'b1, 1'b0);
      end

      // One full frame: count enable, sync and start-of-frame ticks.
      step(1'b1, 1'b1);
      cnt_de = 0; cnt_sof = 0; cnt_hs = 0; cnt_vs = 0;
      for (int i = 0; i < HT * VT; i++) begin
         drive_and_check(1'b1, 1'b0);
         cnt_de  += int'(de_o);
         cnt_sof += int'(sof_o);
         cnt_hs  += int'(hs_o == HS_AH);
         cnt_vs  += int'(vs_o == VS_AH);
         advance(1'b1, 1'b0);
      end
      chk("frame_de_count", cnt_de, W * HGT);
      chk("frame_sof_count", cnt_sof, 1);
      chk("frame_hs_count", cnt_hs, HSP * VT);
      chk("frame_vs_count", cnt_vs, VSP * HT);

      // Alternating enable: hs period doubles in clocks.
      step(1'b1, 1'b1);
      last_rise = -1;
      prev_hs = !HS_AH;
      for (int i = 0; i < 4 * HT * VT; i++) begin
         drive_and_check(i % 2 == 0, 1'b0);
         if ((hs_o == HS_AH) && (prev_hs != HS_AH)) begin
            if (last_rise >= 0) chk("hs_period_half_ce", i - last_rise, 2 * HT);
            last_rise = i;
         end
         prev_hs = hs_o;
         advance(i % 2 == 0, 1'b0);
      end

      // Reset mid-frame while pixels are being displayed.
      step(1'b1, 1'b1);
      while (k < 120) step(1'b1, 1'b0);
      drive_and_check(1'b1, 1'b1);
      chk("midrst_sof", sof_o, 1);
      chk("midrst_vblank", vblank_o, 1);
      chk("midrst_req_v", req_v_o, 0);
      advance(1'b1, 1'b1);
      drive_and_check(1'b0, 1'b0);
      chk("postrst_hs", hs_o, !HS_AH);
      chk("postrst_vs", vs_o, !VS_AH);
      chk("postrst_de", de_o, 0);
      chk("postrst_r", r_o, 0);
      chk("postrst_sof_ce_low", sof_o, 0);
      advance(1'b0, 1'b0);
      for (int i = 0; i < 2 * HT; i++) step(1'b1, 1'b0);

      // Random enable pattern with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         ce  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 499) == 0);
         step(ce, rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
